// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Stage-register control bundle and FSM state encoding.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MDU_WAIT,
    HALT
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic en;
    logic clr;
    logic bb;
  } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance counters.
// Sticks at all-ones once reached; synchronous clear on rst.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // count up on inc, hold at all-ones
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (inc && q != '1)
      q <= q + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Load-use, redirect, MDU occupancy and sticky halt control.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic              id_jump,
  input  logic              ex_branch_taken,
  input  logic              ex_mdu_start,
  input  logic              wb_halt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_clr,
  output logic              ifid_bb,
  output logic              idex_en,
  output logic              idex_clr,
  output logic              exmem_en,
  output logic              exmem_clr,
  output logic              halted,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam bit MDU_MULTI = (MDU_CYCLES > 1);
  localparam logic [3:0] CNT_INIT =
    4'(MDU_CYCLES > 1 ? MDU_CYCLES - 2 : 0);

  localparam stage_ctrl_t GO   = '{en: 1'b1, clr: 1'b0, bb: 1'b0};
  localparam stage_ctrl_t HOLD = '{en: 1'b0, clr: 1'b0, bb: 1'b0};
  localparam stage_ctrl_t WIPE = '{en: 1'b0, clr: 1'b1, bb: 1'b0};

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  stage_ctrl_t pc, ifid, idex, exmem;
  logic        lu, stall_inc, flush_inc;
  logic        unused_bits;

  assign lu = ex_is_load && ex_rd != REG_ZERO &&
              ((id_rs_used && id_rs == ex_rd) ||
               (id_rt_used && id_rt == ex_rd));

  // state and MDU countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next-state and stage controls; reset forces a clear
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pc        = GO;
    ifid      = GO;
    idex      = GO;
    exmem     = GO;
    flush_inc = 1'b0;
    halted    = 1'b0;
    mdu_busy  = 1'b0;
    unique case (state)
      RUN: begin
        if (wb_halt) begin
          pc      = HOLD;
          ifid    = HOLD;
          idex    = HOLD;
          exmem   = HOLD;
          state_n = HALT;
        end else if (ex_branch_taken) begin
          ifid.clr  = 1'b1;
          idex.clr  = 1'b1;
          flush_inc = 1'b1;
        end else if (ex_mdu_start && MDU_MULTI) begin
          pc.en     = 1'b0;
          ifid.en   = 1'b0;
          idex.en   = 1'b0;
          exmem.clr = 1'b1;
          cnt_n     = CNT_INIT;
          state_n   = MDU_WAIT;
        end else if (lu) begin
          pc.en    = 1'b0;
          ifid.en  = 1'b0;
          idex.clr = 1'b1;
        end else if (id_jump) begin
          ifid.clr  = 1'b1;
          flush_inc = 1'b1;
        end
      end
      MDU_WAIT: begin
        pc.en     = 1'b0;
        ifid.en   = 1'b0;
        idex.en   = 1'b0;
        exmem.clr = 1'b1;
        mdu_busy  = 1'b1;
        if (wb_halt)
          state_n = HALT;
        else if (cnt == 4'd0)
          state_n = RUN;
        else
          cnt_n = cnt - 4'd1;
      end
      HALT: begin
        pc     = HOLD;
        ifid   = HOLD;
        idex   = HOLD;
        exmem  = HOLD;
        halted = 1'b1;
      end
      default: state_n = RUN;
    endcase
    if (rst) begin
      pc        = WIPE;
      ifid      = WIPE;
      idex      = WIPE;
      exmem     = WIPE;
      flush_inc = 1'b0;
    end
  end

  assign stall_inc = !rst && state != HALT && !pc.en;

  assign pc_en     = pc.en;
  assign ifid_en   = ifid.en;
  assign ifid_clr  = ifid.clr;
  assign ifid_bb   = ifid.bb;
  assign idex_en   = idex.en;
  assign idex_clr  = idex.clr;
  assign exmem_en  = exmem.en;
  assign exmem_clr = exmem.clr;

  assign unused_bits = ^{pc.clr, pc.bb, idex.bb, exmem.bb};

  sat_counter #(.W(PERF_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_pipe_hazard_ctrl;

  localparam int MC   = 4;
  localparam int PW   = 4;
  localparam int MAXC = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_rs_used = 0, id_rt_used = 0;
  logic          ex_is_load = 0, id_jump = 0;
  logic          ex_branch_taken = 0, ex_mdu_start = 0;
  logic          wb_halt = 0;
  logic          pc_en, ifid_en, ifid_clr, ifid_bb;
  logic          idex_en, idex_clr, exmem_en, exmem_clr;
  logic          halted, mdu_busy;
  logic [PW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MDU_CYCLES(MC), .PERF_W(PW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .wb_halt         (wb_halt),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_clr        (ifid_clr),
    .ifid_bb         (ifid_bb),
    .idex_en         (idex_en),
    .idex_clr        (idex_clr),
    .exmem_en        (exmem_en),
    .exmem_clr       (exmem_clr),
    .halted          (halted),
    .mdu_busy        (mdu_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  bit m_halt = 0;
  int m_wait = 0;
  int m_sc   = 0;
  int m_fc   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_rs_used = 0; id_rt_used = 0;
    ex_is_load = 0; id_jump = 0;
    ex_branch_taken = 0; ex_mdu_start = 0;
    wb_halt = 0; rst = 0;
  endtask

  // bits: pc_en ifid_en ifid_clr ifid_bb idex_en idex_clr
  //       exmem_en exmem_clr halted mdu_busy
  task automatic cycle();
    bit [9:0] e;
    bit       lu;
    bit       fl;
    @(negedge clk);
    lu = ex_is_load && ex_rd != 0 &&
         ((id_rs_used && id_rs == ex_rd) ||
          (id_rt_used && id_rt == ex_rd));
    chk("stall_cnt", 32'(stall_cnt), m_sc);
    chk("flush_cnt", 32'(flush_cnt), m_fc);
    fl = 0;
    e  = 10'b1100101000;
    if (rst)
      e = {8'b00100101, m_halt, m_wait > 0};
    else if (m_halt)
      e = 10'b0000000010;
    else if (m_wait > 0)
      e = 10'b0000001101;
    else if (wb_halt)
      e = 10'b0;
    else if (ex_branch_taken) begin
      e[7] = 1; e[4] = 1; fl = 1;
    end else if (ex_mdu_start && MC > 1) begin
      e[9] = 0; e[8] = 0; e[5] = 0; e[2] = 1;
    end else if (lu) begin
      e[9] = 0; e[8] = 0; e[4] = 1;
    end else if (id_jump) begin
      e[7] = 1; fl = 1;
    end
    chk("ctl", {pc_en, ifid_en, ifid_clr, ifid_bb,
                idex_en, idex_clr, exmem_en, exmem_clr,
                halted, mdu_busy}, 32'(e));
    if (rst) begin
      m_halt = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (!m_halt && !e[9] && m_sc < MAXC) m_sc++;
      if (fl && m_fc < MAXC) m_fc++;
      if (m_halt) begin
      end else if (m_wait > 0) begin
        if (wb_halt) begin
          m_halt = 1; m_wait = 0;
        end else m_wait--;
      end else if (wb_halt)
        m_halt = 1;
      else if (!ex_branch_taken && ex_mdu_start && MC > 1)
        m_wait = MC - 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    int busy_n;
    idle(); rst = 1;
    @(posedge clk); #1;
    do_reset();

    ex_is_load = 1; ex_rd = 5; id_rs = 5; id_rs_used = 1;
    cycle(); idle(); cycle();
    chk("lu_stall", 32'(stall_cnt), 1);

    do_reset();
    ex_is_load = 1; ex_rd = 0; id_rs = 0; id_rs_used = 1;
    cycle(); idle(); cycle();
    chk("zero_reg_stall", 32'(stall_cnt), 0);

    do_reset();
    ex_is_load = 1; ex_rd = 5; id_rs = 5; id_rs_used = 1;
    ex_branch_taken = 1;
    cycle(); idle(); cycle();
    chk("br_flush", 32'(flush_cnt), 1);
    chk("br_stall", 32'(stall_cnt), 0);

    do_reset();
    ex_mdu_start = 1; cycle(); idle();
    busy_n = 0;
    repeat (5) begin
      busy_n += int'(mdu_busy);
      cycle();
    end
    chk("mdu_busy_len", busy_n, MC - 1);
    chk("mdu_stall", 32'(stall_cnt), MC);

    do_reset();
    ex_mdu_start = 1; cycle(); idle();
    cycle();
    wb_halt = 1; cycle(); idle();
    id_jump = 1; ex_is_load = 1;
    repeat (20) cycle();
    chk("halt_sticky", halted, 1);
    chk("halt_stall", 32'(stall_cnt), 3);
    idle(); rst = 1; cycle(); rst = 0;
    chk("rst_halted", halted, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_stall", 32'(stall_cnt), 0);

    do_reset();
    id_jump = 1;
    repeat (20) cycle();
    chk("flush_sat", 32'(flush_cnt), MAXC);
    cycle();
    chk("flush_hold", 32'(flush_cnt), MAXC);

    do_reset();
    repeat (3000) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1));
      id_rt_used = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      id_jump = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mdu_start = !ex_branch_taken &&
                     ($urandom_range(0, 7) == 0);
      wb_halt = ($urandom_range(0, 39) == 0);
      rst = m_halt ? ($urandom_range(0, 7) == 0)
                   : ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable, clear and bubble controls of the PC register and of the IF/ID, ID/EX and EX/MEM stage registers.
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle MDU occupancy and a sticky halt.
- Keeps saturating stall/flush performance counters.

Parameters:
- MDU_CYCLES, 4, total EX-stage occupancy of a mul/div op in cycles; legal range 1..15.
- PERF_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- ex_is_load  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- id_jump  in  1  ID holds an unconditional jump; PC is redirected this cycle.
- ex_branch_taken  in  1  EX resolved a taken branch.
- ex_mdu_start  in  1  EX holds a mul/div op in its first EX cycle.
- wb_halt  in  1  halt/syscall-exit instruction retiring in WB.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID EN.
- ifid_clr  out  1  IF/ID CLR (synchronous clear).
- ifid_bb  out  1  IF/ID bubble-when-held.
- idex_en  out  1  ID/EX load enable.
- idex_clr  out  1  ID/EX clear (insert bubble).
- exmem_en  out  1  EX/MEM load enable.
- exmem_clr  out  1  EX/MEM clear.
- halted  out  1  pipeline frozen by halt.
- mdu_busy  out  1  pipeline held for MDU.
- stall_cnt  out  PERF_W  cycles with pc_en=0 while not halted; saturating.
- flush_cnt  out  PERF_W  redirect events (branch or jump); saturating.

Behaviour:
- FSM states and reset:
  - States: RUN, MDU_WAIT, HALT.
  - Registers: state, cnt[3:0], stall_cnt, flush_cnt.
  - On rst=1 at a clk edge: state=RUN, cnt=0, both perf counters=0, halted=0, mdu_busy=0.
  - While rst is high, outputs are forced: every *_en=0, ifid_clr=idex_clr=exmem_clr=1, ifid_bb=0. Pipeline registers therefore clear on the same edge.
- Control outputs are combinational from state and inputs. Zero-cycle latency: they apply to the current edge.
- Hazard terms:
  - lu = ex_is_load & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
  - Register 0 never causes a hazard.
- Default RUN outputs: all en=1, all clr=0, ifid_bb=0.
- RUN priority, highest first:
  1. wb_halt: all en=0, clr=0; next state HALT.
  2. ex_branch_taken: pc_en=1, ifid_clr=1, idex_clr=1; flush_cnt++. Any simultaneous lu or id_jump is ignored, because the younger instruction is squashed.
  3. ex_mdu_start with MDU_CYCLES>1: pc_en=ifid_en=idex_en=0, exmem_clr=1; cnt=MDU_CYCLES-2; next state MDU_WAIT. With MDU_CYCLES=1, ex_mdu_start is ignored.
  4. lu: pc_en=0, ifid_en=0, ifid_bb=0, idex_clr=1. This gives a one-cycle bubble; the ID instruction is held.
  5. id_jump: ifid_clr=1; flush_cnt++. The delay-free slot is squashed.
- ex_branch_taken together with ex_mdu_start is illegal. The branch term wins.
- MDU_WAIT:
  - Outputs: pc_en=ifid_en=idex_en=0, exmem_clr=1, mdu_busy=1.
  - All hazard and redirect inputs are ignored.
  - If cnt==0: next RUN and EX/MEM loads the MDU result on the following cycle. Otherwise cnt decrements.
  - wb_halt has priority: next HALT. The instruction in WB precedes the MDU op, so halting mid-wait is legal.
- HALT:
  - Outputs: all en=0, all clr=0, halted=1.
  - Sticky; only rst exits.
  - Perf counters freeze.
- MDU timing: total freeze of PC/IF/ID/ID-EX is exactly MDU_CYCLES-1 cycles after the start cycle.
- stall_cnt increments on every cycle (rst=0, state!=HALT) where pc_en=0; it saturates at all-ones.
- flush_cnt saturates at all-ones.
- Performance counter updates happen on the same edge as the event.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State enum {RUN, MDU_WAIT, HALT}.
  - REG_ZERO=5'd0.
  - Struct stage_ctrl_t {en, clr, bb}, reused by every stage register.
- One sub-module, sat_counter (parameter W, inputs clk/rst/inc, output q), instantiated twice for the perf counters.
- Hazard comparison stays inline.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs=5, id_rs_used=1 for one cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle; next cycle all en=1; stall_cnt=1.
- Zero register: same stimulus as load-use with ex_rd=0 -> no stall; stall_cnt stays 0.
- Branch beats load-use: ex_branch_taken=1 together with the lu condition -> pc_en=1, ifid_clr=1, idex_clr=1; flush_cnt=1; stall_cnt=0.
- MDU occupancy: MDU_CYCLES=4, ex_mdu_start pulse -> pc_en=0 and exmem_clr=1 for the start cycle plus 3 MDU_WAIT cycles; mdu_busy=1 for 3 cycles; then RUN; stall_cnt=4.
- Halt mid-MDU: wb_halt=1 during MDU_WAIT -> HALT next cycle; halted=1, all en=0; held for 20 cycles; rst=1 for one cycle -> RUN, counters=0, the reset cycle shows all clr=1.
- Saturation: PERF_W=4, 20 consecutive id_jump cycles -> flush_cnt=15 and holds at 15.
